game_controller: RTL

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_pkg.sv | 26 ++
 rtl/game_controller_frame_timer.sv | 29 ++
 rtl/game_controller.sv | 128 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared state encoding, parameter defaults and score arithmetic for the game controller.
// Pure declarations: no latency, no flow control.
package game_pkg;

    typedef enum logic [2:0] {
        S_ATTRACT   = 3'd0,
        S_READY     = 3'd1,
        S_PLAY      = 3'd2,
        S_DYING     = 3'd3,
        S_CLEAR     = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    localparam int DEF_INIT_LIVES   = 3;
    localparam int DEF_READY_FRAMES = 120;
    localparam int DEF_DEATH_FRAMES = 90;
    localparam int DEF_CLEAR_FRAMES = 60;
    localparam int DEF_DOT_POINTS   = 10;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/game_controller_frame_timer.sv
// Counts frame ticks up to a limit and emits a registered one-cycle done pulse.
// Latency: done follows the limit-th tick by one clock; clear has priority; no backpressure.
module frame_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       frame_tick,
    input  logic [7:0] limit,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
            done  <= 1'b0;
        end else if (clear) begin
            count <= 8'd0;
            done  <= 1'b0;
        end else if (frame_tick) begin
            count <= count + 8'd1;
            done  <= ((count + 8'd1) == limit);
        end else begin
            done  <= 1'b0;
        end
    end

endmodule

// File: rtl/game_controller.sv
// Game-flow FSM: attract, ready, play, dying, level clear, game over; tracks lives, level, score.
// All outputs registered (one clock after the causing input); inputs are sampled, never stalled.
module game_controller
    import game_pkg::*;
#(
    parameter int INIT_LIVES   = DEF_INIT_LIVES,
    parameter int READY_FRAMES = DEF_READY_FRAMES,
    parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
    parameter int CLEAR_FRAMES = DEF_CLEAR_FRAMES,
    parameter int DOT_POINTS   = DEF_DOT_POINTS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_start,
    input  logic        collision,
    input  logic        dot_eaten,
    input  logic        level_done,
    output logic        move_tick,
    output logic        soft_reset,
    output logic [2:0]  state,
    output logic [1:0]  lives,
    output logic [3:0]  level,
    output logic [15:0] score
);

    localparam logic [1:0]  LIVES0    = 2'(INIT_LIVES);
    localparam logic [7:0]  READY_LIM = 8'(READY_FRAMES);
    localparam logic [7:0]  DEATH_LIM = 8'(DEATH_FRAMES);
    localparam logic [7:0]  CLEAR_LIM = 8'(CLEAR_FRAMES);
    localparam logic [15:0] DOT_ADD   = 16'(DOT_POINTS);

    state_t     st;
    logic       btn_q;
    logic       armed;
    logic       start_evt;
    logic       counting;
    logic       tmr_clear;
    logic       tmr_done;
    logic [7:0] tmr_limit;

    // A button already held when reset releases must be let go before it can start a game.
    assign start_evt = btn_start & ~btn_q & armed;

    assign counting  = (st == S_READY) | (st == S_DYING) | (st == S_CLEAR);
    // Every exit from a timed state happens on done, so clearing there gives a zero count on entry.
    assign tmr_clear = ~counting | tmr_done;
    assign tmr_limit = (st == S_READY) ? READY_LIM :
                       (st == S_DYING) ? DEATH_LIM : CLEAR_LIM;

    frame_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (tmr_clear),
        .frame_tick (frame_tick),
        .limit      (tmr_limit),
        .done       (tmr_done)
    );

    assign state = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= S_ATTRACT;
            lives      <= LIVES0;
            level      <= 4'd0;
            score      <= 16'd0;
            move_tick  <= 1'b0;
            soft_reset <= 1'b0;
            btn_q      <= 1'b0;
            armed      <= 1'b0;
        end else begin
            btn_q      <= btn_start;
            armed      <= armed | ~btn_start;
            move_tick  <= 1'b0;
            soft_reset <= 1'b0;
            case (st)
                S_ATTRACT, S_OVER: begin
                    if (start_evt) begin
                        st         <= S_READY;
                        lives      <= LIVES0;
                        level      <= 4'd0;
                        score      <= 16'd0;
                        soft_reset <= 1'b1;
                    end
                end
                S_READY: begin
                    if (tmr_done) begin
                        st        <= S_PLAY;
                        move_tick <= frame_tick;
                    end
                end
                S_PLAY: begin
                    if (dot_eaten)
                        score <= sat_add16(score, DOT_ADD);
                    if (collision)
                        st <= S_DYING;
                    else if (level_done)
                        st <= S_CLEAR;
                    else
                        move_tick <= frame_tick;
                end
                S_DYING: begin
                    if (tmr_done) begin
                        if (lives > 2'd1) begin
                            lives      <= lives - 2'd1;
                            soft_reset <= 1'b1;
                            st         <= S_READY;
                        end else begin
                            lives <= 2'd0;
                            st    <= S_OVER;
                        end
                    end
                end
                S_CLEAR: begin
                    if (tmr_done) begin
                        if (level != 4'hF)
                            level <= level + 4'd1;
                        soft_reset <= 1'b1;
                        st         <= S_READY;
                    end
                end
                default: st <= S_ATTRACT;
            endcase
        end
    end

endmodule
